fp_mul_arbiter: RTL and testbench



---
 rtl/fp_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/fp_mul_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiplier arbiter: rounding modes,
// exception flag positions, canonical NaN encodings and the controller states.
package fp_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // Positions inside the {nv,of,uf,nx} flag nibble.
    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] CANON_NAN32 = 32'h7FC0_0000;
    localparam logic [63:0] CANON_NAN64 = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Encodings 5..7 are reserved and never reach the multiplier.
    function automatic logic rm_is_legal(input logic [2:0] rm);
        return (rm <= RM_RMM);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Produces a one-hot grant plus the granted index.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] sel;

    // Scan from the farthest offset down so the closest hit to ptr wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        sum       = '0;
        sel       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NREQ)) begin
                sum = sum - (IDX_W + 1)'(NREQ);
            end
            sel = sum[IDX_W-1:0];
            if (req[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one multi-cycle FP multiplier among NREQ requesters, round-robin,
// with illegal rounding-mode filtering, a done watchdog and sticky flags.
module fp_mul_arbiter
    import fp_pkg::*;
#(
    parameter int FLEN    = 32,
    parameter int NREQ    = 4,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*FLEN-1:0]  req_a,
    input  logic [NREQ*FLEN-1:0]  req_b,
    input  logic [NREQ*3-1:0]     req_rm,
    input  logic [NREQ*TAG_W-1:0] req_tag,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [FLEN-1:0]       resp_result,
    output logic [3:0]            resp_flags,
    output logic [TAG_W-1:0]      resp_tag,
    output logic                  mul_start,
    output logic [2:0]            mul_rm,
    output logic [FLEN-1:0]       mul_a,
    output logic [FLEN-1:0]       mul_b,
    input  logic                  mul_busy,
    input  logic                  mul_done,
    input  logic [FLEN-1:0]       mul_result,
    input  logic [3:0]            mul_flags,
    output logic [3:0]            fflags_acc,
    input  logic                  fflags_clr,
    output logic                  timeout_err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [63:0]     NAN_WIDE  = (FLEN == 64) ? CANON_NAN64 : {32'h0, CANON_NAN32};
    localparam logic [FLEN-1:0] CANON_NAN = NAN_WIDE[FLEN-1:0];
    localparam logic [3:0]      NV_ONLY   = 4'b0001 << FLAG_NV;

    logic [FLEN-1:0]  a_arr   [NREQ];
    logic [FLEN-1:0]  b_arr   [NREQ];
    logic [2:0]       rm_arr  [NREQ];
    logic [TAG_W-1:0] tag_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]   = req_a[gi*FLEN +: FLEN];
            assign b_arr[gi]   = req_b[gi*FLEN +: FLEN];
            assign rm_arr[gi]  = req_rm[gi*3 +: 3];
            assign tag_arr[gi] = req_tag[gi*TAG_W +: TAG_W];
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0] g_reg, g_next;
    logic [FLEN-1:0]  a_reg, a_next;
    logic [FLEN-1:0]  b_reg, b_next;
    logic [2:0]       rm_reg, rm_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic [FLEN-1:0]  res_reg, res_next;
    logic [3:0]       flags_reg, flags_next;
    logic [WD_W-1:0]  wd_cnt_reg, wd_cnt_next;
    logic             timeout_err_reg, timeout_err_next;
    logic [3:0]       fflags_acc_reg, fflags_acc_next;

    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            rr_ptr_reg      <= '0;
            g_reg           <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            rm_reg          <= '0;
            tag_reg         <= '0;
            res_reg         <= '0;
            flags_reg       <= '0;
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
            fflags_acc_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            rr_ptr_reg      <= rr_ptr_next;
            g_reg           <= g_next;
            a_reg           <= a_next;
            b_reg           <= b_next;
            rm_reg          <= rm_next;
            tag_reg         <= tag_next;
            res_reg         <= res_next;
            flags_reg       <= flags_next;
            wd_cnt_reg      <= wd_cnt_next;
            timeout_err_reg <= timeout_err_next;
            fflags_acc_reg  <= fflags_acc_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        rr_ptr_next      = rr_ptr_reg;
        g_next           = g_reg;
        a_next           = a_reg;
        b_next           = b_reg;
        rm_next          = rm_reg;
        tag_next         = tag_reg;
        res_next         = res_reg;
        flags_next       = flags_reg;
        wd_cnt_next      = wd_cnt_reg;
        timeout_err_next = timeout_err_reg;
        fflags_acc_next  = fflags_acc_reg;
        mul_start        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    g_next   = grant_idx;
                    a_next   = a_arr[grant_idx];
                    b_next   = b_arr[grant_idx];
                    rm_next  = rm_arr[grant_idx];
                    tag_next = tag_arr[grant_idx];
                    if (!rm_is_legal(rm_arr[grant_idx])) begin
                        res_next   = CANON_NAN;
                        flags_next = NV_ONLY;
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!mul_busy) begin
                    mul_start   = 1'b1;
                    wd_cnt_next = '0;
                    state_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mul_done) begin
                    res_next   = mul_result;
                    flags_next = mul_flags;
                    state_next = ST_RESP;
                end else if (wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
                    res_next         = CANON_NAN;
                    flags_next       = NV_ONLY;
                    timeout_err_next = 1'b1;
                    state_next       = ST_RESP;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready[g_reg]) begin
                    fflags_acc_next = fflags_acc_reg | flags_reg;
                    rr_ptr_next     = (g_reg == IDX_W'(NREQ - 1)) ? '0 : g_reg + 1'b1;
                    state_next      = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A clear wins over an OR-in landing in the same cycle.
        if (fflags_clr) begin
            fflags_acc_next = '0;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state_reg == ST_RESP) begin
            resp_valid[g_reg] = 1'b1;
        end
    end

    // Gated by reset_n so the accept pulse drops the moment reset asserts.
    assign req_ready   = (reset_n && state_reg == ST_IDLE) ? grant : '0;
    assign resp_result = res_reg;
    assign resp_flags  = flags_reg;
    assign resp_tag    = tag_reg;
    assign mul_a       = a_reg;
    assign mul_b       = b_reg;
    assign mul_rm      = rm_reg;
    assign fflags_acc  = fflags_acc_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter with a 5-cycle multiplier model whose
// results come from a queue filled alongside the expected responses.
module tb_fp_mul_arbiter;

    localparam int FLEN = 32, NREQ = 4, TAG_W = 5, TIMEOUT = 15;

    logic clk = 1'b0, reset_n = 1'b0;
    logic [NREQ-1:0] req_valid = '0, req_ready, resp_valid, resp_ready = '1;
    logic [NREQ*FLEN-1:0] req_a = '0, req_b = '0;
    logic [NREQ*3-1:0] req_rm = '0;
    logic [NREQ*TAG_W-1:0] req_tag = '0;
    logic [FLEN-1:0] resp_result, mul_a, mul_b;
    logic [FLEN-1:0] mul_result = 32'hDEAD_BEEF;
    logic [3:0] resp_flags, fflags_acc, mul_flags = 4'hF;
    logic [TAG_W-1:0] resp_tag;
    logic mul_start, mul_busy = 1'b0, mul_done = 1'b0, fflags_clr = 1'b0, timeout_err;
    logic [2:0] mul_rm;

    fp_mul_arbiter #(.FLEN(FLEN), .NREQ(NREQ), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_flags(resp_flags), .resp_tag(resp_tag), .mul_start(mul_start),
        .mul_rm(mul_rm), .mul_a(mul_a), .mul_b(mul_b), .mul_busy(mul_busy),
        .mul_done(mul_done), .mul_result(mul_result), .mul_flags(mul_flags),
        .fflags_acc(fflags_acc), .fflags_clr(fflags_clr), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; logic [31:0] res; logic [3:0] flags; logic [4:0] tag; } exp_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [2:0] rm; logic [31:0] res; logic [3:0] flags; } mop_t;

    exp_t sb_q[$];
    mop_t mul_q[$];
    int   grant_log[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   start_cyc = -1, rv_cyc = -1, hs_cyc = -1, start_count = 0, cnt = 0;
    bit   rv_prev = 0, mdl_hang = 0, start_s = 0;
    mop_t cur;

    always @(posedge clk) cyc++;

    // Multiplier model: done pulses 5 cycles after the start cycle; outside the
    // done cycle its result/flag outputs carry garbage on purpose.
    always begin
        @(negedge clk);
        start_s = reset_n && mul_start;
        if (start_s) begin
            start_count++;
            checks++;
            if (mul_q.size() == 0) begin
                errors++;
                $display("FAIL mul_unexpected_start cyc=%0d a=%h b=%h rm=%0d want no start", cyc, mul_a, mul_b, mul_rm);
            end else begin
                cur = mul_q.pop_front();
                if ({mul_a, mul_b, mul_rm} !== {cur.a, cur.b, cur.rm}) begin
                    errors++;
                    $display("FAIL mul_operands got a=%h b=%h rm=%0d want a=%h b=%h rm=%0d", mul_a, mul_b, mul_rm, cur.a, cur.b, cur.rm);
                end
            end
        end
        @(posedge clk); #1;
        mul_done = 1'b0; mul_result = 32'hDEAD_BEEF; mul_flags = 4'hF;
        if (!reset_n) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !mdl_hang) begin
                    mul_done = 1'b1; mul_result = cur.res; mul_flags = cur.flags;
                end
            end
            if (start_s) cnt = 4;
        end
        mul_busy = (cnt > 0);
    end

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (!reset_n) begin
            rv_prev = 0;
        end else begin
            if (|req_ready) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
            end
            if (mul_start) start_cyc = cyc;
            if (|resp_valid && !rv_prev) rv_cyc = cyc;
            rv_prev = |resp_valid;
            if (|(resp_valid & resp_ready)) begin
                hs_cyc = cyc;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected valid=%b result=%h want no response", resp_valid, resp_result);
                end else begin
                    exp_t e;
                    logic [3:0] oh;
                    e = sb_q.pop_front();
                    oh = 4'b0001 << e.idx;
                    if ({resp_valid, resp_result, resp_flags, resp_tag} !== {oh, e.res, e.flags, e.tag}) begin
                        errors++;
                        $display("FAIL resp got valid=%b result=%h flags=%b tag=%h want valid=%b result=%h flags=%b tag=%h",
                                 resp_valid, resp_result, resp_flags, resp_tag, oh, e.res, e.flags, e.tag);
                    end else begin
                        $display("resp req=%0d result=%h flags=%b tag=%h cyc=%0d", e.idx, resp_result, resp_flags, resp_tag, cyc);
                    end
                end
            end
        end
    end

    task automatic reset_dut();
        @(posedge clk); #1;
        reset_n = 1'b0; req_valid = '0; resp_ready = '1; fflags_clr = 1'b0; mdl_hang = 0;
        sb_q.delete(); mul_q.delete(); grant_log.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] rm, input logic [4:0] tag);
        req_a[i*FLEN +: FLEN] = a;
        req_b[i*FLEN +: FLEN] = b;
        req_rm[i*3 +: 3] = rm;
        req_tag[i*TAG_W +: TAG_W] = tag;
    endtask

    task automatic wait_accept(input int i, output int t);
        t = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin t = cyc; break; end
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL accept_timeout req=%0d got req_ready=%b want bit %0d set", i, req_ready, i);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending responses want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_req(0, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 5'h01);
        req_valid = '1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start got %b want 0", mul_start); end
        checks++; if ({resp_result, resp_flags, resp_tag} !== '0) begin errors++; $display("FAIL reset_resp_bus got %h/%b/%h want 0", resp_result, resp_flags, resp_tag); end
        checks++; if ({mul_a, mul_b, mul_rm} !== '0) begin errors++; $display("FAIL reset_mul_bus got %h/%h/%0d want 0", mul_a, mul_b, mul_rm); end
        checks++; if ({fflags_acc, timeout_err} !== '0) begin errors++; $display("FAIL reset_sticky got %b/%b want 0", fflags_acc, timeout_err); end
        req_valid = '0;
        #1 reset_n = 1'b1;
    endtask

    task automatic test_single();
        int t;
        @(posedge clk); #1;
        set_req(2, 32'h4000_0000, 32'h4040_0000, 3'd0, 5'h0A);
        mul_q.push_back('{32'h4000_0000, 32'h4040_0000, 3'd0, 32'h40C0_0000, 4'b0000});
        sb_q.push_back('{2, 32'h40C0_0000, 4'b0000, 5'h0A});
        req_valid[2] = 1'b1;
        wait_accept(2, t);
        @(posedge clk); #1 req_valid[2] = 1'b0;
        wait_drain();
        checks++; if (start_cyc != t + 1) begin errors++; $display("FAIL single_start_latency got %0d want 1", start_cyc - t); end
        checks++; if (rv_cyc != t + 7) begin errors++; $display("FAIL single_resp_latency got %0d want 7", rv_cyc - t); end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int n = 0;
        logic [31:0] av, bv, rv;
        reset_dut();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 32'h3F80_0000 | (i << 8), 32'h4000_0000 | i, i[2:0], 5'(16 + i));
        for (int k = 0; k < 5; k++) begin
            av = 32'h3F80_0000 | (order[k] << 8);
            bv = 32'h4000_0000 | order[k];
            rv = 32'h4100_0000 + k;
            mul_q.push_back('{av, bv, order[k][2:0], rv, (k == 2) ? 4'b0001 : 4'b0000});
            sb_q.push_back('{order[k], rv, (k == 2) ? 4'b0001 : 4'b0000, 5'(16 + order[k])});
        end
        @(posedge clk); #1 req_valid = '1;
        for (int k = 0; k < 200 && n < 5; k++) begin
            @(negedge clk);
            if (|req_ready) n++;
        end
        @(posedge clk); #1 req_valid = '0;
        wait_drain();
        checks++;
        if (grant_log.size() != 5) begin errors++; $display("FAIL rr_grant_count got %0d want 5", grant_log.size()); end
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            checks++;
            if (grant_log[k] != order[k]) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", k, grant_log[k], order[k]); end
        end
    endtask

    task automatic test_illegal_rm();
        int t, sc;
        @(posedge clk); #1;
        set_req(1, 32'h3F80_0000, 32'h3F80_0000, 3'd5, 5'h11);
        sb_q.push_back('{1, 32'h7FC0_0000, 4'b1000, 5'h11});
        sc = start_count;
        req_valid[1] = 1'b1;
        wait_accept(1, t);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_drain();
        checks++; if (rv_cyc != t + 1) begin errors++; $display("FAIL illegal_rm_latency got %0d want 1", rv_cyc - t); end
        checks++; if (start_count != sc) begin errors++; $display("FAIL illegal_rm_started got %0d starts want 0", start_count - sc); end
        checks++; if (fflags_acc[3] !== 1'b1) begin errors++; $display("FAIL illegal_rm_acc_nv got %b want 1xxx", fflags_acc); end
    endtask

    task automatic test_timeout();
        int t;
        @(posedge clk); #1;
        mdl_hang = 1;
        set_req(0, 32'h4000_0000, 32'h4000_0000, 3'd1, 5'h03);
        mul_q.push_back('{32'h4000_0000, 32'h4000_0000, 3'd1, 32'h4080_0000, 4'b0000});
        sb_q.push_back('{0, 32'h7FC0_0000, 4'b1000, 5'h03});
        req_valid[0] = 1'b1;
        wait_accept(0, t);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_drain();
        checks++;
        if (rv_cyc - t < TIMEOUT + 1 || rv_cyc - t > TIMEOUT + 3) begin
            errors++; $display("FAIL timeout_latency got %0d want %0d..%0d", rv_cyc - t, TIMEOUT + 1, TIMEOUT + 3);
        end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", timeout_err); end
        mdl_hang = 0;
        @(posedge clk); #1;
        set_req(3, 32'h3F80_0000, 32'h4040_0000, 3'd4, 5'h1F);
        mul_q.push_back('{32'h3F80_0000, 32'h4040_0000, 3'd4, 32'h4040_0000, 4'b0001});
        sb_q.push_back('{3, 32'h4040_0000, 4'b0001, 5'h1F});
        req_valid[3] = 1'b1;
        wait_accept(3, t);
        @(posedge clk); #1 req_valid[3] = 1'b0;
        wait_drain();
        checks++; if (rv_cyc != t + 7) begin errors++; $display("FAIL after_timeout_latency got %0d want 7", rv_cyc - t); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky got %b want 1", timeout_err); end
    endtask

    task automatic test_back_to_back();
        int t, t1;
        bit stable = 1, seen = 0;
        logic [40:0] snap;
        reset_dut();
        set_req(0, 32'h40A0_0000, 32'h3F00_0000, 3'd2, 5'h05);
        set_req(1, 32'h4040_0000, 32'h4040_0000, 3'd3, 5'h06);
        mul_q.push_back('{32'h40A0_0000, 32'h3F00_0000, 3'd2, 32'h4020_0000, 4'b0000});
        mul_q.push_back('{32'h4040_0000, 32'h4040_0000, 3'd3, 32'h4110_0000, 4'b0000});
        sb_q.push_back('{0, 32'h4020_0000, 4'b0000, 5'h05});
        sb_q.push_back('{1, 32'h4110_0000, 4'b0000, 5'h06});
        resp_ready = 4'b1110;
        req_valid = 4'b0011;
        wait_accept(0, t);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp_valid[0]) begin seen = 1; break; end
        end
        snap = {resp_result, resp_flags, resp_tag};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid !== 4'b0001 || {resp_result, resp_flags, resp_tag} !== snap || req_ready !== '0) stable = 0;
        end
        checks++;
        if (!seen || !stable) begin
            errors++; $display("FAIL backpressure_hold got seen=%0d stable=%0d valid=%b ready=%b want seen=1 stable=1", seen, stable, resp_valid, req_ready);
        end
        @(posedge clk); #1 resp_ready[0] = 1'b1;
        wait_accept(1, t1);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        checks++; if (t1 != hs_cyc + 1) begin errors++; $display("FAIL back_to_back got accept %0d cycles after handshake want 1", t1 - hs_cyc); end
        wait_drain();
    endtask

    task automatic test_reset_mid_wait();
        int t, c;
        bit quiet = 1;
        @(posedge clk); #1;
        set_req(2, 32'h4100_0000, 32'h4000_0000, 3'd0, 5'h07);
        mul_q.push_back('{32'h4100_0000, 32'h4000_0000, 3'd0, 32'h4180_0000, 4'b0000});
        sb_q.push_back('{2, 32'h4180_0000, 4'b0000, 5'h07});
        req_valid[2] = 1'b1;
        wait_accept(2, t);
        @(posedge clk); #1 req_valid[2] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, mul_start, resp_result, resp_flags, resp_tag, mul_a, mul_b, mul_rm, fflags_acc, timeout_err} !== '0) begin
            errors++; $display("FAIL midwait_reset_outputs got valid=%b start=%b result=%h mul_a=%h acc=%b want all 0", resp_valid, mul_start, resp_result, mul_a, fflags_acc);
        end
        sb_q.delete(); mul_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid !== '0 || mul_start !== 1'b0) quiet = 0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL midwait_dropped got activity after reset want none"); end
        @(posedge clk); #1;
        set_req(1, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 5'h08);
        mul_q.push_back('{32'h3F80_0000, 32'h3F80_0000, 3'd0, 32'h3F80_0000, 4'b0000});
        sb_q.push_back('{1, 32'h3F80_0000, 4'b0000, 5'h08});
        c = cyc;
        req_valid[1] = 1'b1;
        wait_accept(1, t);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        checks++; if (t != c) begin errors++; $display("FAIL midwait_idle_accept got accept %0d cycles after drive want 0", t - c); end
        wait_drain();
    endtask

    task automatic test_fflags_clr();
        int t;
        bit seen = 0;
        @(posedge clk); #1;
        resp_ready = '0;
        set_req(3, 32'h3F80_0001, 32'h3F80_0001, 3'd0, 5'h09);
        mul_q.push_back('{32'h3F80_0001, 32'h3F80_0001, 3'd0, 32'h3F80_0002, 4'b0001});
        sb_q.push_back('{3, 32'h3F80_0002, 4'b0001, 5'h09});
        req_valid[3] = 1'b1;
        wait_accept(3, t);
        @(posedge clk); #1 req_valid[3] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp_valid[3]) begin seen = 1; break; end
        end
        @(posedge clk); #1 resp_ready[3] = 1'b1; fflags_clr = 1'b1;
        @(posedge clk); #1 resp_ready = '1; fflags_clr = 1'b0;
        @(negedge clk);
        checks++; if (!seen || fflags_acc !== 4'b0000) begin errors++; $display("FAIL clr_priority got acc=%b seen=%0d want acc=0000 seen=1", fflags_acc, seen); end
        wait_drain();
        @(posedge clk); #1;
        mul_q.push_back('{32'h3F80_0001, 32'h3F80_0001, 3'd0, 32'h3F80_0002, 4'b0001});
        sb_q.push_back('{3, 32'h3F80_0002, 4'b0001, 5'h09});
        req_valid[3] = 1'b1;
        wait_accept(3, t);
        @(posedge clk); #1 req_valid[3] = 1'b0;
        wait_drain();
        @(negedge clk);
        checks++; if (fflags_acc !== 4'b0001) begin errors++; $display("FAIL acc_or_in got %b want 0001", fflags_acc); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_illegal_rm();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        test_fflags_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no completion want finish before 500000");
        $fatal(1, "bench time limit reached");
    end

endmodule
